// File: rtl/teras_wb_initiator_if.sv
// Command, response and Wishbone master signal bundle for teras_wb_initiator.
// Suffixes are seen from the initiator: the master modport is the initiator, and the slave modport is its user or bus slave.
interface teras_wb_initiator_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned SEL_W = DATA_W / 8;

   // command channel
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_we_i;
   logic [ADDR_W-1:0] cmd_adr_i;
   logic [DATA_W-1:0] cmd_dat_i;
   logic [SEL_W-1:0]  cmd_sel_i;

   // response channel
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_dat_o;
   logic              rsp_err_o;

   // Wishbone classic master
   logic              wbm_cyc_o;
   logic              wbm_stb_o;
   logic              wbm_we_o;
   logic [SEL_W-1:0]  wbm_sel_o;
   logic [ADDR_W-1:0] wbm_adr_o;
   logic [DATA_W-1:0] wbm_dat_o;
   logic              wbm_ack_i;
   logic [DATA_W-1:0] wbm_dat_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  rsp_ready_i,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_dat_o, rsp_err_o,
      output rsp_ready_i,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface

// File: rtl/teras_wb_initiator.sv
// Single-outstanding Wishbone classic master. Latency: cyc/stb rise 1 edge after accept; the response is valid on the ack edge.
// Backpressure: a command is taken only in IDLE, and a response is held until rsp_ready_i. TERAS_WB_INITIATOR_TIMEOUT_EN adds a bus-timeout abort.
module teras_wb_initiator #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   teras_wb_initiator_if.master bus,
   output logic                 busy_o
);
   localparam int unsigned SEL_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;
   logic              timeout_hit;
   logic [DATA_W-1:0] timeout_dat;

`ifdef TERAS_WB_INITIATOR_TIMEOUT_EN
   localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [DATA_W-1:0] TMO_DAT  = DATA_W'(32'hDEAD_BEEF);

   logic [15:0] cnt_q, cnt_d;

   // Expiry fires on the edge where the count would reach TIMEOUT_CYC.
   assign timeout_hit = (state_q == S_BUS) && !bus.wbm_ack_i && (cnt_q == TMO_LAST);
   assign timeout_dat = TMO_DAT;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q != S_BUS) begin
         cnt_d = '0;
      end else if (!bus.wbm_ack_i) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign timeout_dat        = '0;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid_i) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               we_d    = bus.cmd_we_i;
               adr_d   = bus.cmd_adr_i;
               dat_d   = bus.cmd_dat_i;
               sel_d   = bus.cmd_sel_i;
            end
         end
         S_BUS: begin
            // A real ack beats a simultaneous timeout.
            if (bus.wbm_ack_i) begin
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
            end else if (timeout_hit) begin
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = timeout_dat;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q     <= S_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready_o = (state_q == S_IDLE);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.wbm_cyc_o   = cyc_q;
   assign bus.wbm_stb_o   = cyc_q;
   assign bus.wbm_we_o    = we_q;
   assign bus.wbm_sel_o   = sel_q;
   assign bus.wbm_adr_o   = adr_q;
   assign bus.wbm_dat_o   = dat_q;
   assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_teras_wb_initiator.sv
// Directed bench for teras_wb_initiator: it drives inputs 1 ns after each rising edge and checks the registered outputs at the same point.
// It covers the timeout cases when TERAS_WB_INITIATOR_TIMEOUT_EN is defined.
module tb_teras_wb_initiator;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   teras_wb_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   teras_wb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .bus       (bus),
      .busy_o    (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      bus.cmd_sel_i   = sel;
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic ack_once(input logic [31:0] dat);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = dat;
      tick();
      bus.wbm_ack_i = 1'b0;
   endtask

   task automatic drain();
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = '0;
      bus.cmd_dat_i   = '0;
      bus.cmd_sel_i   = '0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_dat_i   = '0;
      tick();
      tick();
      chk("rst_cmd_ready", bus.cmd_ready_o, 1);
      chk("rst_cyc",       bus.wbm_cyc_o,   0);
      chk("rst_stb",       bus.wbm_stb_o,   0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_rsp_err",   bus.rsp_err_o,   0);
      chk("rst_rsp_dat",   bus.rsp_dat_o,   0);
      chk("rst_adr",       bus.wbm_adr_o,   0);
      chk("rst_busy",      busy,            0);
      rst_n = 1'b1;
      tick();

      // Read, ack on the first stb cycle
      issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
      chk("rd_cyc",       bus.wbm_cyc_o,   1);
      chk("rd_stb",       bus.wbm_stb_o,   1);
      chk("rd_adr",       bus.wbm_adr_o,   32'h3000_0004);
      chk("rd_we",        bus.wbm_we_o,    0);
      chk("rd_cmd_ready", bus.cmd_ready_o, 0);
      chk("rd_busy",      busy,            1);
      ack_once(32'h1234_5678);
      chk("rd_cyc_drop",  bus.wbm_cyc_o,   0);
      chk("rd_stb_drop",  bus.wbm_stb_o,   0);
      chk("rd_rsp_valid", bus.rsp_valid_o, 1);
      chk("rd_rsp_dat",   bus.rsp_dat_o,   32'h1234_5678);
      chk("rd_rsp_err",   bus.rsp_err_o,   0);
      drain();
      chk("rd_rsp_done",  bus.rsp_valid_o, 0);
      chk("rd_idle",      bus.cmd_ready_o, 1);

      // Write with three wait states
      issue(1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'b0011);
      for (int i = 0; i < 4; i++) begin
         chk("wr_cyc", bus.wbm_cyc_o, 1);
         chk("wr_stb", bus.wbm_stb_o, 1);
         chk("wr_adr", bus.wbm_adr_o, 32'h3000_0000);
         chk("wr_dat", bus.wbm_dat_o, 32'hA5A5_0001);
         chk("wr_sel", bus.wbm_sel_o, 4'b0011);
         chk("wr_we",  bus.wbm_we_o,  1);
         if (i == 3) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = 32'hFFFF_FFFF;
         end
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      chk("wr_cyc_drop",  bus.wbm_cyc_o,   0);
      chk("wr_rsp_valid", bus.rsp_valid_o, 1);
      chk("wr_rsp_dat",   bus.rsp_dat_o,   0);
      chk("wr_rsp_err",   bus.rsp_err_o,   0);
      drain();

      // Response back-pressure with a queued command
      issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
      ack_once(32'hCAFE_F00D);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b1;
      bus.cmd_adr_i   = 32'h3000_000C;
      bus.cmd_dat_i   = 32'h0000_0077;
      bus.cmd_sel_i   = 4'hF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", bus.rsp_valid_o, 1);
         chk("bp_rsp_dat",   bus.rsp_dat_o,   32'hCAFE_F00D);
         chk("bp_cmd_ready", bus.cmd_ready_o, 0);
         chk("bp_no_cyc",    bus.wbm_cyc_o,   0);
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("bp_rsp_gone",  bus.rsp_valid_o, 0);
      chk("bp_idle",      bus.cmd_ready_o, 1);
      chk("bp_not_yet",   bus.wbm_cyc_o,   0);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("bp_accept",    bus.wbm_cyc_o,   1);
      chk("bp_acc_we",    bus.wbm_we_o,    1);
      chk("bp_acc_adr",   bus.wbm_adr_o,   32'h3000_000C);
      ack_once(32'h0);
      drain();

      // Back-to-back throughput with rsp_ready held high: accept at N, ack at N+1, next accept at N+3
      bus.rsp_ready_i = 1'b1;
      issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      bus.cmd_valid_i = 1'b1;
      chk("b2b_cyc",      bus.wbm_cyc_o,   1);
      chk("b2b_zero_adr", bus.wbm_adr_o,   0);
      chk("b2b_zero_sel", bus.wbm_sel_o,   0);
      ack_once(32'h0000_0011);
      chk("b2b_rsp",      bus.rsp_valid_o, 1);
      tick();
      chk("b2b_idle",     bus.cmd_ready_o, 1);
      chk("b2b_gap",      bus.wbm_cyc_o,   0);
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("b2b_next",     bus.wbm_cyc_o,   1);
      ack_once(32'h0);
      tick();
      bus.rsp_ready_i = 1'b0;

      // Reset while the cycle is open
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      chk("mr_cyc",       bus.wbm_cyc_o,   1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mr_cyc_low",   bus.wbm_cyc_o,   0);
      chk("mr_stb_low",   bus.wbm_stb_o,   0);
      chk("mr_rsp_valid", bus.rsp_valid_o, 0);
      chk("mr_cmd_ready", bus.cmd_ready_o, 1);
      chk("mr_adr_clr",   bus.wbm_adr_o,   0);
      ack_once(32'h9999_9999);
      chk("mr_late_ack",  bus.rsp_valid_o, 0);
      chk("mr_late_busy", busy,            0);

      // Spurious acks in IDLE and in RESP
      ack_once(32'h1111_1111);
      chk("sp_idle_busy", busy,            0);
      chk("sp_idle_rsp",  bus.rsp_valid_o, 0);
      chk("sp_idle_rdy",  bus.cmd_ready_o, 1);
      issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
      ack_once(32'h0BAD_F00D);
      ack_once(32'h2222_2222);
      chk("sp_resp_vld",  bus.rsp_valid_o, 1);
      chk("sp_resp_dat",  bus.rsp_dat_o,   32'h0BAD_F00D);
      chk("sp_resp_busy", busy,            1);
      chk("sp_resp_cyc",  bus.wbm_cyc_o,   0);
      drain();
      chk("sp_done",      bus.rsp_valid_o, 0);
      tick();
      chk("sp_no_extra",  bus.rsp_valid_o, 0);

`ifdef TERAS_WB_INITIATOR_TIMEOUT_EN
      // Timeout after 4 BUS cycles with no ack
      issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk("to_cyc_held", bus.wbm_cyc_o, 1);
         tick();
      end
      chk("to_cyc_drop", bus.wbm_cyc_o,   0);
      chk("to_rsp",      bus.rsp_valid_o, 1);
      chk("to_err",      bus.rsp_err_o,   1);
      chk("to_dat",      bus.rsp_dat_o,   32'hDEAD_BEEF);
      drain();

      // Ack on the expiry edge takes priority
      issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) tick();
      chk("tx_cyc_held", bus.wbm_cyc_o, 1);
      ack_once(32'h55AA_55AA);
      chk("tx_rsp",      bus.rsp_valid_o, 1);
      chk("tx_err",      bus.rsp_err_o,   0);
      chk("tx_dat",      bus.rsp_dat_o,   32'h55AA_55AA);
      drain();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
